// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - merges NUM_REQ producer streams onto one FIFO write port; FIFO_ARB_FIXED_PRIO_EN selects fixed priority
// One word per grant: IDLE grants, SEND holds the word until taken, RELEASE drops valid for a cycle.
module fifo_rr_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int WORD_LENGTH = 8,
    localparam int GRANT_W     = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [WORD_LENGTH-1:0]         fifo_data,
    output logic                           fifo_valid,
    input  logic                           fifo_ready,
    output logic [GRANT_W-1:0]             grant_id,
    output logic                           busy
);

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

    state_t                   state;
    state_t                   next_state;
    logic [GRANT_W-1:0]       winner;
    logic                     any_valid;
    logic                     grant;
    logic [WORD_LENGTH-1:0]   words [NUM_REQ];

    assign any_valid = |req_valid;
    assign grant     = (state == IDLE) && any_valid;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[i*WORD_LENGTH +: WORD_LENGTH];
        end
    end

`ifdef FIFO_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest active index is the last to write winner.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                winner = GRANT_W'(i);
            end
        end
    end
`else
    logic [GRANT_W-1:0] last;

    // Scan offsets from farthest to nearest so the first index after last wins.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[GRANT_W'((int'(last) + k) % NUM_REQ)]) begin
                winner = GRANT_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= GRANT_W'(NUM_REQ - 1);
        end else if (grant) begin
            last <= winner;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = SEND;
            SEND:    if (fifo_ready) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
        fifo_valid = (state == SEND);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_data <= '0;
            grant_id  <= '0;
        end else if (grant) begin
            fifo_data <= words[winner];
            grant_id  <= winner;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - self-checking bench for fifo_rr_arbiter (vector table, corner sequences, random vs model)
module tb_fifo_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     fifo_data;
    logic             fifo_valid;
    logic             fifo_ready;
    logic [1:0]       grant_id;
    logic             busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    fifo_rr_arbiter #(.NUM_REQ(N), .WORD_LENGTH(W)) dut (
        .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
        .req_ready(req_ready), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
        .fifo_ready(fifo_ready), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        fr;
        logic [3:0]  e_ready;
        logic        e_fv;
        logic [7:0]  e_fd;
        logic [1:0]  e_gid;
        logic        e_busy;
    } vec_t;

    vec_t tv [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; req_valid = '0; req_data = '0; fifo_ready = 1'b0;
        next_cycle;
        next_cycle;
        reset = 1'b0;
    endtask

    // Reference arbitration: who should win given the previously granted index.
    function automatic int pick(input logic [3:0] v, input int prev);
`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (v[(prev + k) % N]) return (prev + k) % N;
`endif
        return -1;
    endfunction

    int m_phase, m_last, m_gid, w, prev_gc, waited, exp_g;
    logic [7:0] m_data;
    logic [3:0] e_ready;

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; fifo_ready = 1'b0;

        tv.push_back('{1'b0, 4'b0001, 32'h0000_00A5, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0});
        tv.push_back('{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd0, 1'b1});
        tv.push_back('{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b1});
        tv.push_back('{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0});
        tv.push_back('{1'b0, 4'b0100, 32'h003C_0000, 1'b0, 4'b0100, 1'b0, 8'hA5, 2'd0, 1'b0});
        tv.push_back('{1'b0, 4'b0100, 32'h003C_0000, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd2, 1'b1});
        tv.push_back('{1'b0, 4'b0100, 32'h003C_0000, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd2, 1'b1});
        tv.push_back('{1'b0, 4'b0100, 32'h003C_0000, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd2, 1'b1});
        tv.push_back('{1'b0, 4'b0100, 32'h003C_0000, 1'b1, 4'b0100, 1'b0, 8'h3C, 2'd2, 1'b0});
        tv.push_back('{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd2, 1'b1});

        do_reset;
        foreach (tv[i]) begin
            reset = tv[i].rst; req_valid = tv[i].valid; req_data = tv[i].data; fifo_ready = tv[i].fr;
            to_sample;
            check($sformatf("vec%0d_req_ready", i), req_ready, tv[i].e_ready);
            check($sformatf("vec%0d_fifo_valid", i), fifo_valid, tv[i].e_fv);
            check($sformatf("vec%0d_fifo_data", i), fifo_data, tv[i].e_fd);
            check($sformatf("vec%0d_grant_id", i), grant_id, tv[i].e_gid);
            check($sformatf("vec%0d_busy", i), busy, tv[i].e_busy);
            next_cycle;
        end

        // All requesters active: grant order and 3-cycle spacing.
        do_reset;
        req_valid = 4'hF; req_data = 32'h4433_2211; fifo_ready = 1'b1;
        prev_gc = 0;
        for (int g = 0; g < 6; g++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = g % N;
`endif
            waited = 0;
            to_sample;
            while (req_ready == 4'b0 && waited < 6) begin
                next_cycle; to_sample; waited++;
            end
            check("rr_req_ready", req_ready, 32'(1 << exp_g));
            if (g > 0) check("rr_spacing", cyc - prev_gc, 3);
            prev_gc = cyc;
            next_cycle; to_sample;
            check("rr_grant_id", grant_id, exp_g);
            check("rr_fifo_data", fifo_data, 8'h11 * (exp_g + 1));
            next_cycle;
        end

        // FIFO full for 10 cycles: word held, nobody else served.
        do_reset;
        req_valid = 4'b0100; req_data = 32'h003C_0000; fifo_ready = 1'b0;
        to_sample;
        check("stall_grant", req_ready, 4'b0100);
        next_cycle;
        req_valid = 4'b0101;
        for (int k = 0; k <= 10; k++) begin
            fifo_ready = (k == 10);
            to_sample;
            check("stall_fifo_valid", fifo_valid, 1'b1);
            check("stall_fifo_data", fifo_data, 8'h3C);
            check("stall_req_ready", req_ready, 4'b0000);
            next_cycle;
        end
        to_sample;
        check("stall_release_valid", fifo_valid, 1'b0);
        check("stall_release_busy", busy, 1'b1);
        next_cycle;

        // Reset while in SEND discards the word and restarts priority at index 0.
        do_reset;
        req_valid = 4'b0010; req_data = 32'h0000_7700; fifo_ready = 1'b0;
        next_cycle; to_sample;
        check("rst_send_data", fifo_data, 8'h77);
        check("rst_send_valid", fifo_valid, 1'b1);
        next_cycle;
        reset = 1'b1;
        next_cycle;
        reset = 1'b0; req_valid = 4'hF; req_data = 32'h4433_2211; fifo_ready = 1'b1;
        to_sample;
        check("rst_fifo_valid", fifo_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_data", fifo_data, 8'h00);
        check("rst_first_grant", req_ready, 4'b0001);
        next_cycle; to_sample;
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_grant_data", fifo_data, 8'h11);
        next_cycle;

        // Requester 1 pulses valid only while the arbiter is busy: never served.
        do_reset;
        req_valid = 4'b0001; req_data = 32'h0000_BBAA; fifo_ready = 1'b0;
        next_cycle;
        req_valid = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            to_sample;
            check("drop_busy_ready", req_ready, 4'b0000);
            next_cycle;
        end
        req_valid = 4'b0001; fifo_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            to_sample;
            check("drop_ready1", req_ready[1], 1'b0);
            if (fifo_valid) check("drop_grant_id", grant_id, 2'd0);
            next_cycle;
        end

        // Random traffic against the reference model.
        do_reset;
        m_phase = 0; m_data = 8'h00; m_gid = 0; m_last = N - 1;
        for (int c = 0; c < 800; c++) begin
            reset      = ($urandom_range(0, 39) == 0);
            req_valid  = 4'($urandom_range(0, 15));
            req_data   = $urandom;
            fifo_ready = ($urandom_range(0, 2) != 0);
            w = pick(req_valid, m_last);
            e_ready = (m_phase == 0 && w >= 0) ? 4'(1 << w) : 4'b0000;
            to_sample;
            check("rnd_req_ready", req_ready, e_ready);
            check("rnd_fifo_valid", fifo_valid, m_phase == 1);
            check("rnd_fifo_data", fifo_data, m_data);
            check("rnd_grant_id", grant_id, m_gid);
            check("rnd_busy", busy, m_phase != 0);
            if (reset) begin
                m_phase = 0; m_data = 8'h00; m_gid = 0; m_last = N - 1;
            end else if (m_phase == 0) begin
                if (w >= 0) begin
                    m_data = req_data[w*W +: W]; m_gid = w; m_last = w; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (fifo_ready) m_phase = 2;
            end else begin
                m_phase = 0;
            end
            next_cycle;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
